muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand-B mux.
//  Consumes opr_a/opr_b when the decoded op is an M-extension instruction (opcode 0110011, funct7 0000001).
//  Returns a 32-bit result with a start/busy/done handshake so the core can stall while it runs.
// PARAMETERS
//  XLEN   32   operand/result width; the counter is $clog2(XLEN)+1 bits wide.
// PORTS
//  clk     in   1     single clock, rising edge
//  rst_n   in   1     asynchronous, active-low reset
//  start   in   1     request; sampled only in IDLE
//  funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  opr_a   in   XLEN  rs1 operand
//  opr_b   in   XLEN  operand B from the operand mux (rs2 for M ops)
//  busy    out  1     high from the start-accept edge until done falls
//  done    out  1     one-cycle pulse; result is valid in that cycle
//  result  out  XLEN  registered result; held until the next accepted start
// BEHAVIOUR
//  - Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0. The in-flight op is discarded.
//  - FSM states: IDLE, CALC, FIX, DONE.
//  - IDLE with start=1: latch funct3, latch the operand magnitudes and the sign flags, set busy=1, go to CALC with cnt=0.
//  - IDLE fast path replaces CALC:
//      - DIV/DIVU/REM/REMU with opr_b==0 goes straight to DONE.
//      - Div-by-0 result: quotient=32'hFFFF_FFFF; remainder=opr_a.
//      - DIV/REM with opr_a==32'h8000_0000 and opr_b==32'hFFFF_FFFF also goes straight to DONE.
//      - Overflow result: quotient=32'h8000_0000; remainder=0.
//  - CALC, one bit per cycle for 32 cycles; then go to FIX.
//      - Multiply: shift-add on a 64-bit product register.
//      - Divide: restoring division on a 64-bit remainder/quotient register.
//  - FIX (1 cycle):
//      - Negate the product if the operand signs differ (MULH: both signed; MULHSU: only a signed).
//      - Negate the quotient if the signs differ. Give the remainder the sign of the dividend.
//      - Select the output: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
//      - Write result; go to DONE.
//  - DONE (1 cycle): done=1, busy=1. Next state is IDLE. The busy=0 clear takes effect at that IDLE edge.
//  - Latency, counted as edges after the start edge:
//      - Normal ops: done high after edge 34, i.e. 32 CALC + FIX + DONE entry.
//      - Fast path: done high after edge 1.
//  - start while busy is ignored; it is neither queued nor errored.
//  - start in the same cycle as done is ignored. A new op is accepted on the next IDLE cycle.
//  - Operand/funct3 changes after the accept edge have no effect.
//  - All arithmetic is modulo 2^XLEN on the selected word. No exceptions are raised (RISC-V M semantics).
// STRUCTURE
//  - Shared package muldiv_pkg holds:
//      - typedef enum logic[2:0] muldiv_op_e: the funct3 encodings above.
//      - typedef enum logic[1:0] muldiv_state_e: IDLE, CALC, FIX, DONE.
//      - localparam OPC_OP = 7'b0110011 and localparam F7_MULDIV = 7'b0000001.
//  - One optional sub-module, muldiv_negate: a combinational two's-complement conditional negator, used in FIX.
//  - Everything else lives in one always_ff (async rst_n) plus one always_comb for next-state.
// TESTING
//  1. MUL 7 * -3 (32'hFFFF_FFFD) -> result=32'hFFFF_FFEB; done pulses exactly 34 edges after start; busy high throughout.
//  2. MULH/MULHSU/MULHU with a=b=32'h8000_0000:
//       MULH -> 32'h4000_0000
//       MULHSU -> 32'hC000_0000
//       MULHU -> 32'h4000_0000
//  3. DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. Division by 0:
//       DIVU 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, with done 1 edge after start.
//       DIV 32'h8000_0000 / -1 -> 32'h8000_0000 and REM of the same -> 0, also 1-edge latency.
//  5. Busy and done-cycle handshake:
//       Pulse start again at edge 10 of a running MUL with different operands -> ignored; the first result is unchanged.
//       start held high through done -> second op accepted on the first IDLE cycle.
//  6. Assert rst_n=0 at edge 15 of a DIV -> busy, done and result go to 0 immediately (async).
//     After release, a fresh MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator used when fixing result signs.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add / restoring
// divide on magnitudes, then a single sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              na_q, na_d;
  logic              nb_q, nb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  muldiv_op_e      op_in;
  logic            div_in, sa, sb, na, nb, by0, ovf;
  logic [XLEN-1:0] ma, mb, fast_res;

  assign op_in  = muldiv_op_e'(funct3);
  assign div_in = funct3[2];
  assign sa = (op_in == MULH) | (op_in == MULHSU) | (div_in & ~funct3[0]);
  assign sb = (op_in == MULH) | (div_in & ~funct3[0]);
  assign na = sa & opr_a[XLEN-1];
  assign nb = sb & opr_b[XLEN-1];
  assign ma = na ? (~opr_a + XLEN'(1)) : opr_a;
  assign mb = nb ? (~opr_b + XLEN'(1)) : opr_b;
  assign by0 = div_in & (opr_b == '0);
  assign ovf = div_in & ~funct3[0] & (opr_a == MINV) & (opr_b == ONES);

  // Quotient ops get all-ones / MIN, remainder ops get dividend / zero
  always_comb begin
    fast_res = '0;
    if (!funct3[1]) fast_res = by0 ? ONES : MINV;
    else if (by0)   fast_res = opr_a;
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN:0]   div_sh;
  logic [XLEN:0]     div_dif;
  logic [2*XLEN-1:0] div_nxt;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  assign div_sh  = {acc_q, 1'b0};
  assign div_dif = div_sh[2*XLEN:XLEN] - {1'b0, b_q};
  assign div_nxt = div_dif[XLEN]
                 ? div_sh[2*XLEN-1:0]
                 : {div_dif[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};

  logic [2*XLEN-1:0] prod_fx;
  logic [XLEN-1:0]   quot_fx, rem_fx, fix_res;

  muldiv_negate #(.W(2*XLEN)) u_neg_prod (
    .val_i (acc_q),
    .neg_i (na_q ^ nb_q),
    .val_o (prod_fx)
  );

  muldiv_negate #(.W(XLEN)) u_neg_quot (
    .val_i (acc_q[XLEN-1:0]),
    .neg_i (na_q ^ nb_q),
    .val_o (quot_fx)
  );

  muldiv_negate #(.W(XLEN)) u_neg_rem (
    .val_i (acc_q[2*XLEN-1:XLEN]),
    .neg_i (na_q),
    .val_o (rem_fx)
  );

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      op_q == MUL:            fix_res = prod_fx[XLEN-1:0];
      !op_q[2] && op_q != MUL: fix_res = prod_fx[2*XLEN-1:XLEN];
      op_q[2] && !op_q[1]:    fix_res = quot_fx;
      op_q[2] && op_q[1]:     fix_res = rem_fx;
      default:                fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (start) begin
        op_d  = op_in;
        a_d   = ma;
        b_d   = mb;
        na_d  = na;
        nb_d  = nb;
        cnt_d = '0;
        acc_d = {{XLEN{1'b0}}, div_in ? ma : mb};
        if (by0 | ovf) begin
          res_d   = fast_res;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = op_q[2] ? div_nxt : mul_nxt;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MUL;
      a_q     <= '0;
      b_q     <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule
